// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
interface hazard_ctrl_if;
  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic       ID_UseRs;
  logic       ID_UseRt;
  logic       ID_IsBranch;
  logic       BCond;
  logic       ID_MDStart;
  logic       ID_MDRead;
  logic [4:0] EX_Rd;
  logic       EX_RegWr;
  logic       EX_MemRd;
  logic [4:0] MEM_Rd;
  logic       MEM_RegWr;
  logic       PCWr;
  logic       IFIDWr;
  logic       IFIDFlush;
  logic       IDEXFlush;
  logic [1:0] FwdA;
  logic [1:0] FwdB;
  logic       MDBusy;
  logic       MDDone;

  modport master (
    output ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_IsBranch, BCond, ID_MDStart, ID_MDRead,
           EX_Rd, EX_RegWr, EX_MemRd, MEM_Rd, MEM_RegWr,
    input  PCWr, IFIDWr, IFIDFlush, IDEXFlush, FwdA, FwdB, MDBusy, MDDone
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_IsBranch, BCond, ID_MDStart, ID_MDRead,
           EX_Rd, EX_RegWr, EX_MemRd, MEM_Rd, MEM_RegWr,
    output PCWr, IFIDWr, IFIDFlush, IDEXFlush, FwdA, FwdB, MDBusy, MDDone
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline interlock, ID-stage forwarding and multiply/divide busy sequencer.
// HAZARD_DELAY_SLOT_EN: taken branches keep the delay-slot instruction instead of flushing IF/ID.
module hazard_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input logic          Clk,
  input logic          Rst,
  hazard_ctrl_if.slave hz
);

  // state   | meaning
  // RUN     | HI/LO unit idle
  // MD_WAIT | multiply/divide in flight, HI/LO readers and new starts held
  // MD_FIN  | result valid this cycle, MDDone pulses
  typedef enum logic [1:0] {RUN = 2'd0, MD_WAIT = 2'd1, MD_FIN = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             mem_load;

  logic ex_rs, ex_rt, mem_rs, mem_rt;
  logic load_use, br_ex, br_mem, md_stall, stall;

  assign ex_rs  = hz.EX_RegWr  && (hz.EX_Rd  == hz.ID_Rs) && (hz.ID_Rs != 5'd0);
  assign ex_rt  = hz.EX_RegWr  && (hz.EX_Rd  == hz.ID_Rt) && (hz.ID_Rt != 5'd0);
  assign mem_rs = hz.MEM_RegWr && (hz.MEM_Rd == hz.ID_Rs) && (hz.ID_Rs != 5'd0);
  assign mem_rt = hz.MEM_RegWr && (hz.MEM_Rd == hz.ID_Rt) && (hz.ID_Rt != 5'd0);

  assign load_use = hz.EX_MemRd && ((hz.ID_UseRs && ex_rs) || (hz.ID_UseRt && ex_rt));
  assign br_ex    = hz.ID_IsBranch && !hz.EX_MemRd &&
                    ((hz.ID_UseRs && ex_rs) || (hz.ID_UseRt && ex_rt));
  // A load reaching MEM still has no data for the ID comparator: second bubble.
  assign br_mem   = hz.ID_IsBranch && mem_load &&
                    ((hz.ID_UseRs && mem_rs) || (hz.ID_UseRt && mem_rt));
  assign md_stall = (state == MD_WAIT) && (hz.ID_MDRead || hz.ID_MDStart);
  assign stall    = load_use || br_ex || br_mem || md_stall;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= RUN;
      cnt      <= '0;
      mem_load <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mem_load <= hz.EX_MemRd;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (hz.ID_MDStart && !stall) begin
          state_nxt = MD_WAIT;
          cnt_nxt   = CNT_LOAD;
        end
      end
      MD_WAIT: begin
        if (cnt <= CNT_W'(1)) state_nxt = MD_FIN;
        if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
      end
      MD_FIN: begin
        if (hz.ID_MDStart && !stall) begin
          state_nxt = MD_WAIT;
          cnt_nxt   = CNT_LOAD;
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    hz.PCWr      = 1'b0;
    hz.IFIDWr    = 1'b0;
    hz.IFIDFlush = 1'b1;
    hz.IDEXFlush = 1'b1;
    hz.FwdA      = 2'b00;
    hz.FwdB      = 2'b00;
    hz.MDBusy    = (state == MD_WAIT);
    hz.MDDone    = (state == MD_FIN);
    // Reset is asynchronous, so the combinational outputs are forced too.
    if (Rst) begin
      hz.PCWr      = !stall;
      hz.IFIDWr    = !stall;
      hz.IDEXFlush = stall;
`ifdef HAZARD_DELAY_SLOT_EN
      hz.IFIDFlush = 1'b0;
`else
      hz.IFIDFlush = hz.BCond && !stall;
`endif
      if (ex_rs && !hz.EX_MemRd) hz.FwdA = 2'b01;
      else if (mem_rs)           hz.FwdA = 2'b10;
      if (ex_rt && !hz.EX_MemRd) hz.FwdB = 2'b01;
      else if (mem_rt)           hz.FwdB = 2'b10;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with MD_LATENCY=4.
module tb_hazard_ctrl;
  logic Clk;
  logic Rst;
  int   errors = 0;
  int   checks = 0;

  hazard_ctrl_if bus();

  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(6)) dut (.Clk(Clk), .Rst(Rst), .hz(bus));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic clear();
    bus.ID_Rs = 5'd0; bus.ID_Rt = 5'd0; bus.ID_UseRs = 1'b0; bus.ID_UseRt = 1'b0;
    bus.ID_IsBranch = 1'b0; bus.BCond = 1'b0; bus.ID_MDStart = 1'b0; bus.ID_MDRead = 1'b0;
    bus.EX_Rd = 5'd0; bus.EX_RegWr = 1'b0; bus.EX_MemRd = 1'b0;
    bus.MEM_Rd = 5'd0; bus.MEM_RegWr = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    clear();
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); #2;
      checks++; if (bus.PCWr !== 1'b0) begin errors++; $display("FAIL rst_pcwr: got %b want 0", bus.PCWr); end
      checks++; if (bus.IFIDFlush !== 1'b1) begin errors++; $display("FAIL rst_ififlush: got %b want 1", bus.IFIDFlush); end
      checks++; if (bus.IDEXFlush !== 1'b1) begin errors++; $display("FAIL rst_idexflush: got %b want 1", bus.IDEXFlush); end
    end
    @(negedge Clk); Rst = 1'b1; #2;
    checks++; if (bus.PCWr !== 1'b1) begin errors++; $display("FAIL post_rst_pcwr: got %b want 1", bus.PCWr); end
    checks++; if (bus.IFIDWr !== 1'b1) begin errors++; $display("FAIL post_rst_ifidwr: got %b want 1", bus.IFIDWr); end
    checks++; if (bus.FwdA !== 2'b00 || bus.FwdB !== 2'b00) begin errors++; $display("FAIL post_rst_fwd: got %b/%b want 00/00", bus.FwdA, bus.FwdB); end
    checks++; if (bus.MDBusy !== 1'b0 || bus.MDDone !== 1'b0) begin errors++; $display("FAIL post_rst_md: got %b/%b want 0/0", bus.MDBusy, bus.MDDone); end
  endtask

  task automatic test_forwarding();
    @(negedge Clk); clear();
    bus.EX_Rd = 5'd5; bus.EX_RegWr = 1'b1; bus.MEM_Rd = 5'd5; bus.MEM_RegWr = 1'b1; bus.ID_Rs = 5'd5;
    #2;
    checks++; if (bus.FwdA !== 2'b01) begin errors++; $display("FAIL fwd_ex_prio: got %b want 01", bus.FwdA); end
    bus.EX_RegWr = 1'b0; #1;
    checks++; if (bus.FwdA !== 2'b10) begin errors++; $display("FAIL fwd_mem: got %b want 10", bus.FwdA); end
    bus.ID_Rs = 5'd0; bus.EX_Rd = 5'd0; bus.EX_RegWr = 1'b1; bus.MEM_Rd = 5'd0; #1;
    checks++; if (bus.FwdA !== 2'b00) begin errors++; $display("FAIL fwd_r0: got %b want 00", bus.FwdA); end
    bus.ID_Rt = 5'd7; bus.MEM_Rd = 5'd7; bus.EX_Rd = 5'd6; #1;
    checks++; if (bus.FwdB !== 2'b10) begin errors++; $display("FAIL fwdb_mem: got %b want 10", bus.FwdB); end
    bus.EX_Rd = 5'd7; #1;
    checks++; if (bus.FwdB !== 2'b01) begin errors++; $display("FAIL fwdb_ex: got %b want 01", bus.FwdB); end
  endtask

  task automatic test_load_use();
    @(negedge Clk); clear();
    bus.EX_MemRd = 1'b1; bus.EX_RegWr = 1'b1; bus.EX_Rd = 5'd8; bus.ID_Rt = 5'd8; bus.ID_UseRt = 1'b1;
    #2;
    checks++; if (bus.PCWr !== 1'b0 || bus.IFIDWr !== 1'b0) begin errors++; $display("FAIL lu_hold: got %b/%b want 0/0", bus.PCWr, bus.IFIDWr); end
    checks++; if (bus.IDEXFlush !== 1'b1) begin errors++; $display("FAIL lu_bubble: got %b want 1", bus.IDEXFlush); end
    @(negedge Clk);
    bus.EX_MemRd = 1'b0; bus.EX_RegWr = 1'b0; bus.EX_Rd = 5'd0; bus.MEM_Rd = 5'd8; bus.MEM_RegWr = 1'b1;
    #2;
    checks++; if (bus.PCWr !== 1'b1 || bus.IDEXFlush !== 1'b0) begin errors++; $display("FAIL lu_release: got %b/%b want 1/0", bus.PCWr, bus.IDEXFlush); end
    checks++; if (bus.FwdB !== 2'b10) begin errors++; $display("FAIL lu_fwdb: got %b want 10", bus.FwdB); end
  endtask

  task automatic test_branch();
    logic exp_flush;
`ifdef HAZARD_DELAY_SLOT_EN
    exp_flush = 1'b0;
`else
    exp_flush = 1'b1;
`endif
    @(negedge Clk); clear();
    bus.ID_IsBranch = 1'b1; bus.BCond = 1'b1; #2;
    checks++; if (bus.IFIDFlush !== exp_flush || bus.PCWr !== 1'b1) begin errors++; $display("FAIL br_taken: got flush=%b pcwr=%b want %b/1", bus.IFIDFlush, bus.PCWr, exp_flush); end
    bus.EX_MemRd = 1'b1; bus.EX_RegWr = 1'b1; bus.EX_Rd = 5'd8; bus.ID_Rt = 5'd8; bus.ID_UseRt = 1'b1; #1;
    checks++; if (bus.IFIDFlush !== 1'b0 || bus.IDEXFlush !== 1'b1) begin errors++; $display("FAIL br_stalled: got %b/%b want 0/1", bus.IFIDFlush, bus.IDEXFlush); end
    // branch on ALU result in EX: one bubble, then MEM forwarding
    @(negedge Clk); clear();
    bus.ID_IsBranch = 1'b1; bus.ID_UseRs = 1'b1; bus.ID_Rs = 5'd3; bus.EX_Rd = 5'd3; bus.EX_RegWr = 1'b1; #2;
    checks++; if (bus.PCWr !== 1'b0) begin errors++; $display("FAIL br_ex_stall: got %b want 0", bus.PCWr); end
    @(negedge Clk);
    bus.EX_RegWr = 1'b0; bus.EX_Rd = 5'd0; bus.MEM_Rd = 5'd3; bus.MEM_RegWr = 1'b1; #2;
    checks++; if (bus.PCWr !== 1'b1 || bus.FwdA !== 2'b10) begin errors++; $display("FAIL br_ex_release: got %b/%b want 1/10", bus.PCWr, bus.FwdA); end
    // branch on load: two bubbles
    @(negedge Clk); clear();
    bus.ID_IsBranch = 1'b1; bus.ID_UseRs = 1'b1; bus.ID_Rs = 5'd4;
    bus.EX_Rd = 5'd4; bus.EX_RegWr = 1'b1; bus.EX_MemRd = 1'b1; #2;
    checks++; if (bus.PCWr !== 1'b0) begin errors++; $display("FAIL br_ld_stall1: got %b want 0", bus.PCWr); end
    @(negedge Clk);
    bus.EX_Rd = 5'd0; bus.EX_RegWr = 1'b0; bus.EX_MemRd = 1'b0; bus.MEM_Rd = 5'd4; bus.MEM_RegWr = 1'b1; #2;
    checks++; if (bus.PCWr !== 1'b0 || bus.IDEXFlush !== 1'b1) begin errors++; $display("FAIL br_ld_stall2: got %b/%b want 0/1", bus.PCWr, bus.IDEXFlush); end
    @(negedge Clk);
    bus.MEM_Rd = 5'd0; bus.MEM_RegWr = 1'b0; #2;
    checks++; if (bus.PCWr !== 1'b1) begin errors++; $display("FAIL br_ld_release: got %b want 1", bus.PCWr); end
  endtask

  task automatic test_md();
    @(negedge Clk); clear();
    bus.ID_MDStart = 1'b1; #2;
    checks++; if (bus.PCWr !== 1'b1 || bus.MDBusy !== 1'b0) begin errors++; $display("FAIL md_issue: got %b/%b want 1/0", bus.PCWr, bus.MDBusy); end
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); bus.ID_MDStart = 1'b0; bus.ID_MDRead = 1'b1; #2;
      checks++; if (bus.MDBusy !== 1'b1 || bus.MDDone !== 1'b0) begin errors++; $display("FAIL md_busy[%0d]: got %b/%b want 1/0", i, bus.MDBusy, bus.MDDone); end
      checks++; if (bus.PCWr !== 1'b0) begin errors++; $display("FAIL md_mfhi_hold[%0d]: got %b want 0", i, bus.PCWr); end
    end
    @(negedge Clk); #2;
    checks++; if (bus.MDDone !== 1'b1 || bus.MDBusy !== 1'b0) begin errors++; $display("FAIL md_done: got %b/%b want 1/0", bus.MDDone, bus.MDBusy); end
    checks++; if (bus.PCWr !== 1'b1) begin errors++; $display("FAIL md_mfhi_issue: got %b want 1", bus.PCWr); end
    @(negedge Clk); bus.ID_MDRead = 1'b0; #2;
    checks++; if (bus.MDDone !== 1'b0 || bus.MDBusy !== 1'b0) begin errors++; $display("FAIL md_idle: got %b/%b want 0/0", bus.MDDone, bus.MDBusy); end
  endtask

  task automatic test_back_to_back();
    @(negedge Clk); clear(); bus.ID_MDStart = 1'b1;
    @(negedge Clk); bus.ID_MDStart = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk); bus.ID_MDStart = 1'b1; #2;
    checks++; if (bus.MDDone !== 1'b1 || bus.PCWr !== 1'b1) begin errors++; $display("FAIL b2b_fin_issue: got %b/%b want 1/1", bus.MDDone, bus.PCWr); end
    @(negedge Clk); #2;
    checks++; if (bus.MDBusy !== 1'b1 || bus.PCWr !== 1'b0) begin errors++; $display("FAIL b2b_start_hold: got %b/%b want 1/0", bus.MDBusy, bus.PCWr); end
    bus.ID_MDStart = 1'b0;
    @(negedge Clk); #2;
    checks++; if (bus.MDBusy !== 1'b1) begin errors++; $display("FAIL b2b_busy2: got %b want 1", bus.MDBusy); end
    @(negedge Clk); #2;
    checks++; if (bus.MDBusy !== 1'b1 || bus.MDDone !== 1'b0) begin errors++; $display("FAIL b2b_busy3: got %b/%b want 1/0", bus.MDBusy, bus.MDDone); end
    @(negedge Clk); #2;
    checks++; if (bus.MDDone !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", bus.MDDone); end
    @(negedge Clk); #2;
    checks++; if (bus.MDDone !== 1'b0 || bus.MDBusy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b/%b want 0/0", bus.MDDone, bus.MDBusy); end
  endtask

  task automatic test_reset_mid_md();
    int done_seen;
    done_seen = 0;
    @(negedge Clk); clear(); bus.ID_MDStart = 1'b1;
    @(negedge Clk); bus.ID_MDStart = 1'b0;
    @(negedge Clk); #2;
    Rst = 1'b0; #1;
    checks++; if (bus.MDBusy !== 1'b0 || bus.PCWr !== 1'b0) begin errors++; $display("FAIL rst_md_abort: got %b/%b want 0/0", bus.MDBusy, bus.PCWr); end
    @(negedge Clk); Rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk); #2;
      if (bus.MDDone !== 1'b0 || bus.MDBusy !== 1'b0) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL rst_md_nodone: got %0d busy/done cycles want 0", done_seen); end
    bus.ID_MDRead = 1'b1; #1;
    checks++; if (bus.PCWr !== 1'b1) begin errors++; $display("FAIL rst_md_run: got %b want 1", bus.PCWr); end
    @(negedge Clk); clear();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_md();
    test_back_to_back();
    test_reset_mid_md();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline interlock and scheduling controller for the five-stage core.
- Observes register operands in the decode stage, destinations in EX and MEM, the branch decision and multiply/divide activity.
- Drives the PC and IF/ID write enables, the IF/ID and ID/EX flushes, and the ID-stage forwarding selects.
- Owns the multi-cycle multiply/divide busy sequencer, so the fixed-latency HI/LO unit is shared safely between instructions.

Parameters:
- MD_LATENCY, 32, multiply/divide latency in cycles (≥2).
- CNT_W, 6, width of the MD countdown counter; must hold MD_LATENCY-1.

Ports:
- Clk  in  1  core clock, rising edge.
- Rst  in  1  asynchronous reset, active-low.
- ID_Rs  in  5  decode-stage source register 1.
- ID_Rt  in  5  decode-stage source register 2.
- ID_UseRs  in  1  ID instruction reads Rs.
- ID_UseRt  in  1  ID instruction reads Rt.
- ID_IsBranch  in  1  ID instruction is a branch or jump-register (compares/uses operands in ID).
- BCond  in  1  branch taken, evaluated in ID.
- ID_MDStart  in  1  ID instruction starts multiply/divide.
- ID_MDRead  in  1  ID instruction reads HI/LO (mfhi/mflo).
- EX_Rd  in  5  EX destination register.
- EX_RegWr  in  1  EX writes the register file.
- EX_MemRd  in  1  EX instruction is a load.
- MEM_Rd  in  5  MEM destination register.
- MEM_RegWr  in  1  MEM writes the register file.
- PCWr  out  1  PC update enable.
- IFIDWr  out  1  IF/ID register enable.
- IFIDFlush  out  1  zero the IF/ID register (kill fetched instruction).
- IDEXFlush  out  1  insert a bubble into ID/EX.
- FwdA  out  2  RsVal source: 00 regfile, 01 EX result, 10 MEM result.
- FwdB  out  2  RtVal source, same encoding as FwdA.
- MDBusy  out  1  multiply/divide in progress.
- MDDone  out  1  one-cycle pulse when the HI/LO result is valid.

Behaviour:
- Reset (Rst=0, asynchronous): state=RUN, counter=0, PCWr=0, IFIDWr=0, IFIDFlush=1, IDEXFlush=1, FwdA=FwdB=00, MDBusy=0, MDDone=0.
- Matching rules:
  - Register 0 never matches.
  - matchEX(r) = EX_RegWr & EX_Rd==r & r!=0.
  - matchMEM(r) = MEM_RegWr & MEM_Rd==r & r!=0.
- Forwarding (combinational, zero latency):
  - FwdA=01 if matchEX(ID_Rs) & ~EX_MemRd; else 10 if matchMEM(ID_Rs); else 00.
  - EX has priority over MEM.
  - FwdB is identical using ID_Rt.
- Stall sources (combinational; any one asserted gives stall=1):
  - Load-use: EX_MemRd & ((ID_UseRs & matchEX(ID_Rs)) | (ID_UseRt & matchEX(ID_Rt))).
  - Branch-on-EX: ID_IsBranch & ~EX_MemRd & operand matchEX. Comparator in ID cannot take EX result this cycle.
  - HI/LO: state==MD_WAIT & (ID_MDRead | ID_MDStart).
- On stall: PCWr=0, IFIDWr=0, IDEXFlush=1, IFIDFlush=0. BCond is ignored while stalled.
- No stall: PCWr=1, IFIDWr=1, IDEXFlush=0.
- Load-use and branch-on-EX each cause exactly one bubble. The next cycle the producer is in MEM and is served by forwarding.
- Branch-on-MEM-load (branch operand is a load now in MEM) stalls one more cycle. This is covered by the branch rule applied to MEM with MEM-load context, giving 2 bubbles total.
- FSM states: RUN, MD_WAIT, MD_FIN.
  - RUN → MD_WAIT when ID_MDStart & ~stall. Counter loads MD_LATENCY-1.
  - MD_WAIT: counter decrements each cycle. At counter==1 → MD_FIN.
  - MD_FIN: MDDone=1 for one cycle. HI/LO readers are released this cycle. → RUN, or directly → MD_WAIT if ID_MDStart & no other stall (back-to-back MD).
  - MDBusy = (state==MD_WAIT).
- Timing: an MD instruction issued at cycle T gives MDDone at T+MD_LATENCY. mfhi issued in ID at any cycle < T+MD_LATENCY waits and leaves ID on the MDDone cycle.
- Simultaneous events: stall overrides branch flush, and the flush is re-evaluated after the stall clears. Reset mid-MD aborts the operation; MDDone is not produced.
- Counter never underflows. Only the states listed are reachable; any other encoding → RUN.

Optional Feature:
- Macro: HAZARD_DELAY_SLOT_EN.
- Defined: MIPS branch delay slot. Taken branch (BCond & ~stall) does not assert IFIDFlush; the fetched instruction executes.
- Undefined: BCond & ~stall asserts IFIDFlush=1 for that cycle, killing the wrong-path instruction; PCWr=1 loads the target.

Test Plan:
- Reset held 3 cycles then released, no hazards → during reset PCWr=0, IFIDFlush=1; first cycle after release PCWr=1, IFIDWr=1, FwdA=FwdB=00.
- Forwarding:
  - EX_Rd=5, EX_RegWr=1, MEM_Rd=5, MEM_RegWr=1, ID_Rs=5 → FwdA=01.
  - Drop EX_RegWr → FwdA=10.
  - ID_Rs=0 with EX_Rd=0 → FwdA=00.
- Load-use: EX_MemRd=1, EX_Rd=8, ID_Rt=8, ID_UseRt=1 → exactly one cycle PCWr=0, IFIDWr=0, IDEXFlush=1. Next cycle (load in MEM) → FwdB=10, PCWr=1.
- MD_LATENCY=4: ID_MDStart at cycle 10 → MDBusy=1 cycles 11–13, MDDone=1 at cycle 14. mfhi in ID from cycle 11 stalls through 13, issues at 14.
- Branch: BCond=1 with no stall → IFIDFlush=1 (macro undefined) / 0 (HAZARD_DELAY_SLOT_EN). BCond=1 coincident with load-use stall → IFIDFlush=0, IDEXFlush=1.
- Rst pulsed low in MD_WAIT with counter=2 → MDBusy=0 immediately, no MDDone pulse afterwards, state RUN.
